hqm_reorder_pipe_flr_seq: RTL and testbench

FLR-prep sequencer for the reorder pipe (ROP). It raises `flr_prep` to the ROP interface-protection stage, which gates the ROP ready, idle and reset-done status signals. It then waits for the ROP to drain to a stable idle state, issues a single VF reset request, and waits for the ROP VF reset-done. Finally it reports completion back to the FLR requester.

---
 rtl/hqm_reorder_pipe_flr_seq.sv | 133 +++++++++++++
 tb/tb_hqm_reorder_pipe_flr_seq.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/hqm_reorder_pipe_flr_seq.sv
// FLR-prep sequencer for the reorder pipe: protect, drain, VF reset, report done.
// Optional drain/reset-wait timeout counter is built when HQM_ROP_FLR_TIMEOUT_EN is defined.
module hqm_reorder_pipe_flr_seq #(
    parameter int IDLE_STABLE_CNT = 8,
    parameter int TIMEOUT_W       = 16
) (
    input  logic       hqm_gated_clk,
    input  logic       hqm_gated_rst_n,
    input  logic       flr_req,
    input  logic       rop_unit_idle,
    input  logic       rop_unit_pipeidle,
    input  logic       rop_vf_reset_done,
    output logic       flr_prep,
    output logic       rop_vf_reset_req,
    output logic       flr_done,
    output logic       flr_timeout_alarm,
    output logic       flr_timeout_sts,
    output logic [2:0] flr_state
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_PREP    = 3'd1;
    localparam logic [2:0] ST_DRAIN   = 3'd2;
    localparam logic [2:0] ST_VFRST   = 3'd3;
    localparam logic [2:0] ST_WAITRST = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    localparam logic [7:0] STABLE_LAST = 8'(IDLE_STABLE_CNT - 1);

    logic [2:0] state;
    logic [2:0] next_state;
    logic [7:0] stable_cnt;
    logic       both_idle;
    logic       prep_nxt;
    logic       req_nxt;
    logic       done_nxt;

    assign both_idle = rop_unit_idle & rop_unit_pipeidle;
    assign flr_state = state;

    // State and outputs share one register stage so outputs always match flr_state.
    always_ff @(posedge hqm_gated_clk or negedge hqm_gated_rst_n) begin
        if (!hqm_gated_rst_n) begin
            state            <= ST_IDLE;
            flr_prep         <= 1'b0;
            rop_vf_reset_req <= 1'b0;
            flr_done         <= 1'b0;
        end else begin
            state            <= next_state;
            flr_prep         <= prep_nxt;
            rop_vf_reset_req <= req_nxt;
            flr_done         <= done_nxt;
        end
    end

    always_comb begin
        next_state = ST_IDLE;
        case (state)
            ST_IDLE:    next_state = flr_req ? ST_PREP : ST_IDLE;
            ST_PREP:    next_state = flr_req ? ST_DRAIN : ST_IDLE;
            ST_DRAIN: begin
                if (!flr_req)
                    next_state = ST_IDLE;
                else if (both_idle && (stable_cnt == STABLE_LAST))
                    next_state = ST_VFRST;
                else
                    next_state = ST_DRAIN;
            end
            ST_VFRST:   next_state = ST_WAITRST;
            ST_WAITRST: next_state = rop_vf_reset_done ? ST_DONE : ST_WAITRST;
            ST_DONE:    next_state = flr_req ? ST_DONE : ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        prep_nxt = (next_state != ST_IDLE);
        req_nxt  = (next_state == ST_VFRST);
        done_nxt = (next_state == ST_DONE);
    end

    // Any idle dropout restarts the stability window from zero.
    always_ff @(posedge hqm_gated_clk or negedge hqm_gated_rst_n) begin
        if (!hqm_gated_rst_n)
            stable_cnt <= 8'd0;
        else if ((state == ST_DRAIN) && both_idle)
            stable_cnt <= stable_cnt + 8'd1;
        else
            stable_cnt <= 8'd0;
    end

`ifdef HQM_ROP_FLR_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TMO_MAX     = '1;
    localparam logic [TIMEOUT_W-1:0] TMO_PRE_MAX = ~TIMEOUT_W'(1);

    logic [TIMEOUT_W-1:0] tmo_cnt;
    logic                 tmo_alarm;
    logic                 tmo_sts;
    logic                 tmo_active;
    logic                 tmo_entry;
    logic                 tmo_hit;

    assign tmo_active = (state == ST_DRAIN) || (state == ST_WAITRST);
    assign tmo_entry  = ((next_state == ST_DRAIN) || (next_state == ST_WAITRST)) &&
                        (next_state != state);
    assign tmo_hit    = tmo_active && !tmo_entry && (tmo_cnt == TMO_PRE_MAX);

    always_ff @(posedge hqm_gated_clk or negedge hqm_gated_rst_n) begin
        if (!hqm_gated_rst_n) begin
            tmo_cnt   <= '0;
            tmo_alarm <= 1'b0;
            tmo_sts   <= 1'b0;
        end else begin
            tmo_alarm <= tmo_hit;
            if (tmo_entry || (state == ST_IDLE))
                tmo_cnt <= '0;
            else if (tmo_active && (tmo_cnt != TMO_MAX))
                tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_hit)
                tmo_sts <= 1'b1;
            else if ((state == ST_IDLE) && (next_state == ST_PREP))
                tmo_sts <= 1'b0;
        end
    end

    assign flr_timeout_alarm = tmo_alarm;
    assign flr_timeout_sts   = tmo_sts;
`else
    assign flr_timeout_alarm = 1'b0;
    assign flr_timeout_sts   = 1'b0;
`endif

endmodule

// File: tb/tb_hqm_reorder_pipe_flr_seq.sv
// Directed bench for hqm_reorder_pipe_flr_seq: vector table plus timeout and reset sequences.
module tb_hqm_reorder_pipe_flr_seq;

`ifdef HQM_ROP_FLR_TIMEOUT_EN
    localparam logic TMO = 1'b1;
`else
    localparam logic TMO = 1'b0;
`endif

    typedef struct {
        int         rep;
        logic [3:0] stim;   // {flr_req, rop_unit_idle, rop_unit_pipeidle, rop_vf_reset_done}
        logic [2:0] st;
        logic [2:0] outs;   // {flr_prep, rop_vf_reset_req, flr_done}
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       flr_req;
    logic       rop_unit_idle;
    logic       rop_unit_pipeidle;
    logic       rop_vf_reset_done;
    logic       flr_prep;
    logic       rop_vf_reset_req;
    logic       flr_done;
    logic       flr_timeout_alarm;
    logic       flr_timeout_sts;
    logic [2:0] flr_state;

    int   total = 0;
    int   bad   = 0;
    vec_t vecs[$];

    hqm_reorder_pipe_flr_seq #(
        .IDLE_STABLE_CNT(8),
        .TIMEOUT_W(4)
    ) dut (
        .hqm_gated_clk(clk),
        .hqm_gated_rst_n(rst_n),
        .flr_req(flr_req),
        .rop_unit_idle(rop_unit_idle),
        .rop_unit_pipeidle(rop_unit_pipeidle),
        .rop_vf_reset_done(rop_vf_reset_done),
        .flr_prep(flr_prep),
        .rop_vf_reset_req(rop_vf_reset_req),
        .flr_done(flr_done),
        .flr_timeout_alarm(flr_timeout_alarm),
        .flr_timeout_sts(flr_timeout_sts),
        .flr_state(flr_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(int rep, logic [3:0] stim, logic [2:0] st, logic [2:0] outs);
        vec_t v;
        v.rep  = rep;
        v.stim = stim;
        v.st   = st;
        v.outs = outs;
        return v;
    endfunction

    task automatic check(string name, logic [2:0] st, logic [2:0] outs, logic alarm, logic sts);
        logic [7:0] act;
        logic [7:0] exp;
        act = {flr_state, flr_prep, rop_vf_reset_req, flr_done, flr_timeout_alarm, flr_timeout_sts};
        exp = {st, outs, alarm, sts};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: {state,prep,req,done,alarm,sts} got %b want %b",
                     name, $time, act, exp);
        end
    endtask

    task automatic step(string name, logic [3:0] stim, logic [2:0] st, logic [2:0] outs,
                        logic alarm, logic sts);
        {flr_req, rop_unit_idle, rop_unit_pipeidle, rop_vf_reset_done} = stim;
        @(posedge clk);
        #1;
        check(name, st, outs, alarm, sts);
    endtask

    initial begin
        rst_n = 1'b0;
        {flr_req, rop_unit_idle, rop_unit_pipeidle, rop_vf_reset_done} = 4'b0000;

        // nominal
        vecs.push_back(mk(2, 4'b0110, 3'd0, 3'b000));
        vecs.push_back(mk(1, 4'b1110, 3'd1, 3'b100));
        vecs.push_back(mk(1, 4'b1110, 3'd2, 3'b100));
        vecs.push_back(mk(7, 4'b1110, 3'd2, 3'b100));
        vecs.push_back(mk(1, 4'b1110, 3'd3, 3'b110));
        vecs.push_back(mk(1, 4'b1110, 3'd4, 3'b100));
        vecs.push_back(mk(3, 4'b1110, 3'd4, 3'b100));
        vecs.push_back(mk(1, 4'b1111, 3'd5, 3'b101));
        vecs.push_back(mk(3, 4'b1110, 3'd5, 3'b101));
        vecs.push_back(mk(1, 4'b0110, 3'd0, 3'b000));
        // idle dropout 5 cycles into DRAIN restarts the 8-cycle window
        vecs.push_back(mk(1, 4'b1110, 3'd1, 3'b100));
        vecs.push_back(mk(1, 4'b1110, 3'd2, 3'b100));
        vecs.push_back(mk(5, 4'b1110, 3'd2, 3'b100));
        vecs.push_back(mk(1, 4'b1100, 3'd2, 3'b100));
        vecs.push_back(mk(7, 4'b1110, 3'd2, 3'b100));
        vecs.push_back(mk(1, 4'b1110, 3'd3, 3'b110));
        vecs.push_back(mk(1, 4'b1110, 3'd4, 3'b100));
        vecs.push_back(mk(1, 4'b1111, 3'd5, 3'b101));
        vecs.push_back(mk(1, 4'b0110, 3'd0, 3'b000));
        // abort 3 cycles into DRAIN, abort in PREP, abort at the threshold
        vecs.push_back(mk(1, 4'b1110, 3'd1, 3'b100));
        vecs.push_back(mk(1, 4'b1110, 3'd2, 3'b100));
        vecs.push_back(mk(3, 4'b1110, 3'd2, 3'b100));
        vecs.push_back(mk(1, 4'b0110, 3'd0, 3'b000));
        vecs.push_back(mk(2, 4'b0110, 3'd0, 3'b000));
        vecs.push_back(mk(1, 4'b1110, 3'd1, 3'b100));
        vecs.push_back(mk(1, 4'b0110, 3'd0, 3'b000));
        vecs.push_back(mk(1, 4'b1110, 3'd1, 3'b100));
        vecs.push_back(mk(1, 4'b1110, 3'd2, 3'b100));
        vecs.push_back(mk(7, 4'b1110, 3'd2, 3'b100));
        vecs.push_back(mk(1, 4'b0110, 3'd0, 3'b000));
        // late drop; early reset-done pulses in DRAIN and VFRST are missed
        vecs.push_back(mk(1, 4'b1110, 3'd1, 3'b100));
        vecs.push_back(mk(1, 4'b1110, 3'd2, 3'b100));
        vecs.push_back(mk(7, 4'b1111, 3'd2, 3'b100));
        vecs.push_back(mk(1, 4'b1110, 3'd3, 3'b110));
        vecs.push_back(mk(1, 4'b0111, 3'd4, 3'b100));
        vecs.push_back(mk(2, 4'b0110, 3'd4, 3'b100));
        vecs.push_back(mk(1, 4'b0111, 3'd5, 3'b101));
        vecs.push_back(mk(1, 4'b0110, 3'd0, 3'b000));

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 3'd0, 3'b000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].rep; r++)
                step($sformatf("vec%0d_c%0d", i, r), vecs[i].stim, vecs[i].st, vecs[i].outs,
                     1'b0, 1'b0);
        end

        // timeout: unit never idle, alarm 15 cycles after DRAIN entry
        step("tmo_prep", 4'b1000, 3'd1, 3'b100, 1'b0, 1'b0);
        step("tmo_drain", 4'b1000, 3'd2, 3'b100, 1'b0, 1'b0);
        for (int k = 1; k <= 20; k++)
            step($sformatf("tmo_k%0d", k), 4'b1000, 3'd2, 3'b100,
                 TMO && (k == 15), TMO && (k >= 15));
        step("tmo_sts_idle0", 4'b0000, 3'd0, 3'b000, 1'b0, TMO);
        step("tmo_sts_idle1", 4'b0000, 3'd0, 3'b000, 1'b0, TMO);
        step("tmo_sts_clear", 4'b1110, 3'd1, 3'b100, 1'b0, 1'b0);
        step("tmo_back_idle", 4'b0110, 3'd0, 3'b000, 1'b0, 1'b0);

        // async reset during WAITRST, then restart from PREP with no replayed request
        step("rst_prep", 4'b1110, 3'd1, 3'b100, 1'b0, 1'b0);
        step("rst_drain", 4'b1110, 3'd2, 3'b100, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++)
            step("rst_drain_n", 4'b1110, 3'd2, 3'b100, 1'b0, 1'b0);
        step("rst_vfrst", 4'b1110, 3'd3, 3'b110, 1'b0, 1'b0);
        step("rst_waitrst", 4'b1110, 3'd4, 3'b100, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", 3'd0, 3'b000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step("rst_restart", 4'b1110, 3'd1, 3'b100, 1'b0, 1'b0);
        step("rst_restart_drain", 4'b1110, 3'd2, 3'b100, 1'b0, 1'b0);
        step("rst_end", 4'b0110, 3'd0, 3'b000, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
